decode_issue: RTL and testbench

Decode/issue stage of the pipelined RISC-V core. It sits directly upstream of `register_file`:
- accepts fetched instructions over a valid/ready handshake;
- decodes fields and immediates;
- drives the register-file read addresses so read data lines up with the issued slot;
- blocks issue on register hazards using a pending-write scoreboard cleared by writeback.

One registered output slot feeds execute.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/imm_decode.sv | 39 +++
 rtl/decode_issue.sv | 164 ++++++++++++++++
 tb/tb_decode_issue.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: widths, base opcodes and immediate formats.
package riscv_pkg;

    localparam int RV_XLEN = 32;
    localparam int RV_AW   = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    function automatic logic is_legal(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to format and sign-extended immediate.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [XLEN-1:0] i_inst,
    output imm_fmt_e        o_fmt,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_fmt = FMT_NONE;
        case (i_inst[6:0])
            OPC_LUI, OPC_AUIPC:            o_fmt = FMT_U;
            OPC_JAL:                       o_fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: o_fmt = FMT_I;
            OPC_STORE:                     o_fmt = FMT_S;
            OPC_BRANCH:                    o_fmt = FMT_B;
            default:                       o_fmt = FMT_NONE;
        endcase
    end

    // OP and illegal opcodes fall into FMT_NONE and carry a zero immediate.
    always_comb begin
        o_imm = '0;
        case (o_fmt)
            FMT_I:   o_imm = {{(XLEN-11){i_inst[31]}}, i_inst[30:20]};
            FMT_S:   o_imm = {{(XLEN-11){i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
            FMT_B:   o_imm = {{(XLEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25],
                              i_inst[11:8], 1'b0};
            FMT_U:   o_imm = {{(XLEN-31){i_inst[31]}}, i_inst[30:12], 12'b0};
            FMT_J:   o_imm = {{(XLEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20],
                              i_inst[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: field decode, pending-write scoreboard, one registered issue slot
// and register-file read address steering.
module decode_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN,
    parameter int A    = RV_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic [A-1:0]      rf_raddr1,
    output logic [A-1:0]      rf_raddr2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic [A-1:0]      out_rs1,
    output logic [A-1:0]      out_rs2,
    output logic [A-1:0]      out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_we,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [A-1:0]      wb_rd,
    input  logic              flush,
    output logic [2**A-1:0]   dbg_pending
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [A-1:0]    w_rs1;
    logic [A-1:0]    w_rs2;
    logic [A-1:0]    w_rd;
    imm_fmt_e        w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_legal;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_writes_rd;
    logic            w_hazard;
    logic            w_accept;
    logic [2**A-1:0] w_pending_nxt;

    logic [2**A-1:0] r_pending;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [6:0]      r_out_opcode;
    logic [2:0]      r_out_funct3;
    logic            r_out_funct7b5;
    logic [A-1:0]    r_out_rs1;
    logic [A-1:0]    r_out_rs2;
    logic [A-1:0]    r_out_rd;
    logic [XLEN-1:0] r_out_imm;
    logic            r_out_we;
    logic            r_out_illegal;

    assign w_opcode   = in_inst[6:0];
    assign w_funct3   = in_inst[14:12];
    assign w_funct7b5 = in_inst[30];
    assign w_rs1      = in_inst[19:15];
    assign w_rs2      = in_inst[24:20];
    assign w_rd       = in_inst[11:7];

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .i_inst (in_inst),
        .o_fmt  (w_fmt),
        .o_imm  (w_imm)
    );

    // Stores and branches are the only legal formats without a destination.
    assign w_legal     = is_legal(w_opcode);
    assign w_uses_rs1  = w_legal && !(w_opcode == OPC_LUI || w_opcode == OPC_AUIPC
                                      || w_opcode == OPC_JAL);
    assign w_uses_rs2  = (w_fmt == FMT_S) || (w_fmt == FMT_B) || (w_opcode == OPC_OP);
    assign w_writes_rd = w_legal && (w_rd != '0) && (w_fmt != FMT_S) && (w_fmt != FMT_B);

    assign w_hazard = in_valid && ((w_uses_rs1  && r_pending[w_rs1]) ||
                                   (w_uses_rs2  && r_pending[w_rs2]) ||
                                   (w_writes_rd && r_pending[w_rd]));

    // Handshake: a transfer happens on an edge where valid && ready. Upstream holds
    // in_inst/in_pc while in_valid waits; the slot holds every out_* field while
    // out_valid && !out_ready. in_ready never depends on a registered in_valid.
    assign in_ready = !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Later writes win: flush release, then writeback clear, then issue set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (flush && r_out_valid && r_out_we) begin
            w_pending_nxt[r_out_rd] = 1'b0;
        end
        if (wb_valid) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        if (w_accept && w_writes_rd) begin
            w_pending_nxt[w_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending      <= '0;
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_opcode   <= '0;
            r_out_funct3   <= '0;
            r_out_funct7b5 <= 1'b0;
            r_out_rs1      <= '0;
            r_out_rs2      <= '0;
            r_out_rd       <= '0;
            r_out_imm      <= '0;
            r_out_we       <= 1'b0;
            r_out_illegal  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_out_pc       <= in_pc;
                r_out_opcode   <= w_opcode;
                r_out_funct3   <= w_funct3;
                r_out_funct7b5 <= w_funct7b5;
                r_out_rs1      <= w_rs1;
                r_out_rs2      <= w_rs2;
                r_out_rd       <= w_rd;
                r_out_imm      <= w_imm;
                r_out_we       <= w_writes_rd;
                r_out_illegal  <= !w_legal;
            end
        end
    end

    // Read addresses lead the slot by one cycle so RF data aligns with the issued slot.
    assign rf_raddr1 = w_accept ? w_rs1 : r_out_rs1;
    assign rf_raddr2 = w_accept ? w_rs2 : r_out_rs2;

    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_opcode   = r_out_opcode;
    assign out_funct3   = r_out_funct3;
    assign out_funct7b5 = r_out_funct7b5;
    assign out_rs1      = r_out_rs1;
    assign out_rs2      = r_out_rs2;
    assign out_rd       = r_out_rd;
    assign out_imm      = r_out_imm;
    assign out_we       = r_out_we;
    assign out_illegal  = r_out_illegal;
    assign dbg_pending  = r_pending;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: reset checks, decode vector table, hazard/back-pressure/flush/reset
// sequences, then randomized traffic against a behavioural model.
module tb_decode_issue;

    localparam int XLEN = 32;
    localparam int A    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;
    logic [XLEN-1:0] in_pc;
    logic [A-1:0]    rf_raddr1;
    logic [A-1:0]    rf_raddr2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [A-1:0]    out_rs1;
    logic [A-1:0]    out_rs2;
    logic [A-1:0]    out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_we;
    logic            out_illegal;
    logic            wb_valid;
    logic [A-1:0]    wb_rd;
    logic            flush;
    logic [31:0]     dbg_pending;

    decode_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_we       (out_we),
        .out_illegal  (out_illegal),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .dbg_pending  (dbg_pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode ----------------
    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        we;
        logic        ill;
        logic        u1;
        logic        u2;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] inst);
        dec_t d;
        logic [11:0] i12;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        i12 = inst[31:20];
        s12 = {inst[31:25], inst[11:7]};
        b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d.opcode = inst[6:0];
        d.f3     = inst[14:12];
        d.f7b5   = inst[30];
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.rd     = inst[11:7];
        d.imm = 32'h0; d.we = 1'b0; d.ill = 1'b0; d.u1 = 1'b0; d.u2 = 1'b0;
        case (d.opcode)
            7'b0110111, 7'b0010111: begin d.imm = {inst[31:12], 12'h000}; d.we = 1'b1; end
            7'b1101111: begin d.imm = 32'($signed(j21)); d.we = 1'b1; end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                d.imm = 32'($signed(i12)); d.u1 = 1'b1; d.we = 1'b1;
            end
            7'b1100011: begin d.imm = 32'($signed(b13)); d.u1 = 1'b1; d.u2 = 1'b1; end
            7'b0100011: begin d.imm = 32'($signed(s12)); d.u1 = 1'b1; d.u2 = 1'b1; end
            7'b0110011: begin d.u1 = 1'b1; d.u2 = 1'b1; d.we = 1'b1; end
            default:    d.ill = 1'b1;
        endcase
        if (d.rd == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    // ---------------- model state for random phase ----------------
    bit          mdl_pend [32];
    logic        m_valid;
    dec_t        m;
    logic [31:0] m_pc;

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        for (int k = 0; k < 32; k++) v[k] = mdl_pend[k];
        return v;
    endfunction

    task automatic check_slot();
        chk("rnd_out_valid", out_valid, m_valid);
        chk("rnd_out_pc", out_pc, m_pc);
        chk("rnd_out_opcode", out_opcode, m.opcode);
        chk("rnd_out_funct3", out_funct3, m.f3);
        chk("rnd_out_funct7b5", out_funct7b5, m.f7b5);
        chk("rnd_out_rs1", out_rs1, m.rs1);
        chk("rnd_out_rs2", out_rs2, m.rs2);
        chk("rnd_out_rd", out_rd, m.rd);
        chk("rnd_out_imm", out_imm, m.imm);
        chk("rnd_out_we", out_we, m.we);
        chk("rnd_out_illegal", out_illegal, m.ill);
        chk("rnd_pending", dbg_pending, pend_vec());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t tbl [15];
    logic [6:0] ops [11];

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom;
        x[6:0]   = ops[$urandom_range(0, 10)];
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        return x;
    endfunction

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        dec_t        d;
        logic        haz;
        logic        exp_rdy;
        logic        acc;
        logic [4:0]  rd;

        tbl[0]  = '{32'h00500093, 32'h00000005, 1'b1, 1'b0};
        tbl[1]  = '{32'h0020A423, 32'h00000008, 1'b0, 1'b0};
        tbl[2]  = '{32'hFE208EE3, 32'hFFFFFFFC, 1'b0, 1'b0};
        tbl[3]  = '{32'h123451B7, 32'h12345000, 1'b1, 1'b0};
        tbl[4]  = '{32'h008000EF, 32'h00000008, 1'b1, 1'b0};
        tbl[5]  = '{32'hFFDFF2EF, 32'hFFFFFFFC, 1'b1, 1'b0};
        tbl[6]  = '{32'h010100E7, 32'h00000010, 1'b1, 1'b0};
        tbl[7]  = '{32'hFFF1A203, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[8]  = '{32'h80000317, 32'h80000000, 1'b1, 1'b0};
        tbl[9]  = '{32'h402083B3, 32'h00000000, 1'b1, 1'b0};
        tbl[10] = '{32'h00100013, 32'h00000001, 1'b0, 1'b0};
        tbl[11] = '{32'h0000007F, 32'h00000000, 1'b0, 1'b1};
        tbl[12] = '{32'h12345677, 32'h00000000, 1'b0, 1'b1};
        tbl[13] = '{32'hFE112C23, 32'hFFFFFFF8, 1'b0, 1'b0};
        tbl[14] = '{32'h004190E3, 32'h00000800, 1'b0, 1'b0};
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111, 7'b0001011};

        // ---- reset ----
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_raddr1", rf_raddr1, 0);
        chk("rst_raddr2", rf_raddr2, 0);
        chk("rst_pending", dbg_pending, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // ---- addi x1,x0,5 then RAW-blocked add x2,x1,x1 ----
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
        #1 chk("addi_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("addi_out_valid", out_valid, 1);
        chk("addi_out_rd", out_rd, 1);
        chk("addi_out_imm", out_imm, 5);
        chk("addi_out_we", out_we, 1);
        chk("addi_out_pc", out_pc, 32'h100);
        chk("addi_pending", dbg_pending, 32'h2);
        @(negedge clk);
        in_inst = 32'h00108133; in_pc = 32'h104;
        #1 chk("raw_blocked", in_ready, 0);
        @(posedge clk); #1;
        chk("raw_slot_drained", out_valid, 0);
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1 chk("raw_no_wb_bypass", in_ready, 0);
        @(posedge clk); #1;
        chk("raw_wb_cleared", dbg_pending, 0);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        chk("raw_release_ready", in_ready, 1);
        chk("raw_raddr1", rf_raddr1, 1);
        chk("raw_raddr2", rf_raddr2, 1);
        @(posedge clk); #1;
        chk("raw_out_valid", out_valid, 1);
        chk("raw_out_rd", out_rd, 2);
        chk("raw_out_rs1", out_rs1, 1);
        chk("raw_out_rs2", out_rs2, 1);
        chk("raw_out_imm", out_imm, 0);
        chk("raw_pending", dbg_pending, 32'h4);
        @(negedge clk);
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2;
        @(posedge clk); #1;
        chk("raw_retire_x2", dbg_pending, 0);
        @(negedge clk) wb_valid = 1'b0;

        // ---- decode vector table ----
        for (int i = 0; i < 15; i++) begin
            rd = tbl[i].inst[11:7];
            @(negedge clk);
            in_valid = 1'b1; in_inst = tbl[i].inst; in_pc = 32'h1000 + 32'(i * 4);
            #1;
            chk("tbl_in_ready", in_ready, 1);
            chk("tbl_raddr1", rf_raddr1, tbl[i].inst[19:15]);
            chk("tbl_raddr2", rf_raddr2, tbl[i].inst[24:20]);
            @(posedge clk); #1;
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_out_pc", out_pc, 32'h1000 + 32'(i * 4));
            chk("tbl_out_opcode", out_opcode, tbl[i].inst[6:0]);
            chk("tbl_out_funct3", out_funct3, tbl[i].inst[14:12]);
            chk("tbl_out_funct7b5", out_funct7b5, tbl[i].inst[30]);
            chk("tbl_out_rs1", out_rs1, tbl[i].inst[19:15]);
            chk("tbl_out_rs2", out_rs2, tbl[i].inst[24:20]);
            chk("tbl_out_rd", out_rd, rd);
            chk("tbl_out_imm", out_imm, tbl[i].imm);
            chk("tbl_out_we", out_we, tbl[i].we);
            chk("tbl_out_illegal", out_illegal, tbl[i].ill);
            chk("tbl_pending", dbg_pending, tbl[i].we ? (32'h1 << rd) : 32'h0);
            @(negedge clk);
            in_valid = 1'b0; wb_valid = tbl[i].we; wb_rd = rd;
            @(posedge clk); #1;
            chk("tbl_retired", dbg_pending, 0);
            @(negedge clk) wb_valid = 1'b0;
        end

        // ---- lui x3 held under back-pressure, then flushed ----
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h123451B7; in_pc = 32'h200; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept_pending", dbg_pending, 32'h8);
        @(negedge clk);
        in_inst = 32'h00100013; in_pc = 32'h204; out_ready = 1'b0;
        #1 chk("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_imm", out_imm, 32'h12345000);
            chk("bp_out_rd", out_rd, 3);
            chk("bp_out_pc", out_pc, 32'h200);
            chk("bp_raddr1", rf_raddr1, 8);
            chk("bp_raddr2", rf_raddr2, 3);
        end
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_pending", dbg_pending, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // ---- reset asserted mid-stall ----
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mrst_pre_pending", dbg_pending, 32'h2);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_rd", out_rd, 0);
        chk("mrst_out_imm", out_imm, 0);
        chk("mrst_out_we", out_we, 0);
        chk("mrst_out_pc", out_pc, 0);
        chk("mrst_raddr1", rf_raddr1, 0);
        chk("mrst_pending", dbg_pending, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 32; k++) mdl_pend[k] = 1'b0;
        m_valid = 1'b0;
        m = '{opcode: '0, f3: '0, f7b5: 1'b0, rs1: '0, rs2: '0, rd: '0, imm: '0,
              we: 1'b0, ill: 1'b0, u1: 1'b0, u2: 1'b0};
        m_pc = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            d = ref_decode(in_inst);
            haz = in_valid && ((d.u1 && mdl_pend[d.rs1]) || (d.u2 && mdl_pend[d.rs2]) ||
                               (d.we && mdl_pend[d.rd]));
            exp_rdy = !flush && !haz && (!m_valid || out_ready);
            acc = in_valid && exp_rdy;
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_raddr1", rf_raddr1, acc ? d.rs1 : m.rs1);
            chk("rnd_raddr2", rf_raddr2, acc ? d.rs2 : m.rs2);
            if (flush && m_valid && m.we) mdl_pend[m.rd] = 1'b0;
            if (wb_valid) mdl_pend[wb_rd] = 1'b0;
            if (acc && d.we) mdl_pend[d.rd] = 1'b1;
            if (flush)          m_valid = 1'b0;
            else if (acc)       m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
            if (acc) begin
                m    = d;
                m_pc = in_pc;
            end
            @(posedge clk); #1;
            check_slot();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
